// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode constants, ALU operation encoding, FSM state type and decode helpers
// for the single-bus CPU control sequencer. ALU_SEQ_MULDIV_EN enables mul/div decode.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHRA = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_ROR  = 4'd5,
        ALU_ROL  = 4'd6,
        ALU_SHR  = 4'd7,
        ALU_SHRA = 4'd8,
        ALU_SHL  = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_DIV  = 4'd11,
        ALU_NEG  = 4'd12,
        ALU_NOT  = 4'd13
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6
    } state_t;

    // Execute-phase shape of an instruction: how many states and which strobes.
    typedef enum logic [1:0] {
        CLS_BIN, CLS_UN, CLS_MD, CLS_ILL
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t cls;
        cls = CLS_ILL;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:        cls = CLS_BIN;
            OP_NEG, OP_NOT:                         cls = CLS_UN;
`ifdef ALU_SEQ_MULDIV_EN
            OP_MUL, OP_DIV:                         cls = CLS_MD;
`else
            OP_MUL, OP_DIV:                         cls = CLS_ILL;
`endif
            default:                                cls = CLS_ILL;
        endcase
        return cls;
    endfunction

    function automatic alu_op_t op_to_alu(input logic [4:0] op);
        alu_op_t alu;
        alu = ALU_NOP;
        case (op)
            OP_ADD:  alu = ALU_ADD;
            OP_SUB:  alu = ALU_SUB;
            OP_AND:  alu = ALU_AND;
            OP_OR:   alu = ALU_OR;
            OP_ROR:  alu = ALU_ROR;
            OP_ROL:  alu = ALU_ROL;
            OP_SHR:  alu = ALU_SHR;
            OP_SHRA: alu = ALU_SHRA;
            OP_SHL:  alu = ALU_SHL;
            OP_MUL:  alu = ALU_MUL;
            OP_DIV:  alu = ALU_DIV;
            OP_NEG:  alu = ALU_NEG;
            OP_NOT:  alu = ALU_NOT;
            default: alu = ALU_NOP;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// 4-to-16 one-hot register-file select decoder with an enable; all outputs
// are low when disabled.
module reg_sel_decoder (
    input  logic        i_en,
    input  logic [3:0]  i_sel,
    output logic [15:0] o_onehot
);

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_dec
            assign o_onehot[gi] = i_en && (i_sel == 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Fetch/execute control sequencer for the single-bus CPU datapath with a
// memory-ready wait/timeout in T1. Define ALU_SEQ_MULDIV_EN to decode mul/div (T6).
module alu_ctrl_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15    // valid range 1..15 (4-bit counter)
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] IR,
    output logic        out_PC,
    output logic        MAR_in,
    output logic        IncPC,
    output logic        Z_in,
    output logic        out_Z_LO,
    output logic        out_Z_HI,
    output logic        PC_in,
    output logic        Read,
    output logic        MDR_in,
    output logic        out_MDR,
    output logic        IR_in,
    output logic        Y_in,
    output logic        in_HI,
    output logic        in_LO,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out,
    output logic [3:0]  alu_op,
    output logic        busy,
    output logic        instr_done,
    output logic        illegal_op,
    output logic        mem_timeout
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

    state_t    r_state;
    state_t    w_state_next;
    state_t    w_end_state;
    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_next;
    logic      r_mem_timeout;
    logic      w_timeout_set;

    op_class_t w_cls;
    alu_op_t   w_alu;
    alu_op_t   w_alu_op;
    logic [3:0] w_ra;
    logic [3:0] w_rb;
    logic [3:0] w_rc;
    logic      w_rin_en;
    logic      w_rout_en;
    logic [3:0] w_rout_sel;
    logic      w_unused_ir;

    assign w_cls       = op_class(IR[31:27]);
    assign w_alu       = op_to_alu(IR[31:27]);
    assign w_ra        = IR[26:23];
    assign w_rb        = IR[22:19];
    assign w_rc        = IR[18:15];
    assign w_unused_ir = ^IR[14:0];
    assign w_end_state = run ? ST_T0 : ST_IDLE;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            if (w_timeout_set) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_wait_next   = r_wait_cnt;
        w_timeout_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A timed-out sequencer stays parked until Clear.
                if (run && !r_mem_timeout) begin
                    w_state_next = ST_T0;
                end
            end
            ST_T0: begin
                w_state_next = ST_T1;
                w_wait_next  = '0;
            end
            ST_T1: begin
                if (mem_ready) begin
                    w_state_next = ST_T2;
                end else begin
                    w_wait_next = r_wait_cnt + 4'd1;
                    if (r_wait_cnt == WAIT_LAST) begin
                        w_state_next  = ST_IDLE;
                        w_timeout_set = 1'b1;
                    end
                end
            end
            ST_T2: w_state_next = ST_T3;
            ST_T3: w_state_next = (w_cls == CLS_ILL) ? ST_T0 : ST_T4;
            ST_T4: w_state_next = (w_cls == CLS_BIN || w_cls == CLS_MD) ? ST_T5 : w_end_state;
            ST_T5: w_state_next = (w_cls == CLS_MD) ? ST_T6 : w_end_state;
            default: w_state_next = w_end_state;
        endcase
    end

    always_comb begin
        out_PC     = 1'b0;
        MAR_in     = 1'b0;
        IncPC      = 1'b0;
        Z_in       = 1'b0;
        out_Z_LO   = 1'b0;
        out_Z_HI   = 1'b0;
        PC_in      = 1'b0;
        Read       = 1'b0;
        MDR_in     = 1'b0;
        out_MDR    = 1'b0;
        IR_in      = 1'b0;
        Y_in       = 1'b0;
        in_HI      = 1'b0;
        in_LO      = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        w_alu_op   = ALU_NOP;
        w_rin_en   = 1'b0;
        w_rout_en  = 1'b0;
        w_rout_sel = w_ra;
        case (r_state)
            ST_T0: begin
                out_PC = 1'b1;
                MAR_in = 1'b1;
                IncPC  = 1'b1;
                Z_in   = 1'b1;
            end
            ST_T1: begin
                out_Z_LO = 1'b1;
                PC_in    = (r_wait_cnt == 4'd0);   // counter is zero only in the first T1 cycle
                Read     = 1'b1;
                MDR_in   = 1'b1;
            end
            ST_T2: begin
                out_MDR = 1'b1;
                IR_in   = 1'b1;
            end
            ST_T3: begin
                case (w_cls)
                    CLS_BIN: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_rb;
                        Y_in       = 1'b1;
                    end
                    CLS_UN: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_rb;
                        w_alu_op   = w_alu;
                        Z_in       = 1'b1;
                    end
                    CLS_MD: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_ra;
                        Y_in       = 1'b1;
                    end
                    default: illegal_op = 1'b1;
                endcase
            end
            ST_T4: begin
                case (w_cls)
                    CLS_BIN: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_rc;
                        w_alu_op   = w_alu;
                        Z_in       = 1'b1;
                    end
                    CLS_UN: begin
                        out_Z_LO   = 1'b1;
                        w_rin_en   = 1'b1;
                        instr_done = 1'b1;
                    end
                    CLS_MD: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_rb;
                        w_alu_op   = w_alu;
                        Z_in       = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (w_cls)
                    CLS_BIN: begin
                        out_Z_LO   = 1'b1;
                        w_rin_en   = 1'b1;
                        instr_done = 1'b1;
                    end
                    CLS_MD: begin
                        out_Z_LO = 1'b1;
                        in_LO    = 1'b1;
                    end
                    default: ;
                endcase
            end
`ifdef ALU_SEQ_MULDIV_EN
            ST_T6: begin
                out_Z_HI   = 1'b1;
                in_HI      = 1'b1;
                instr_done = 1'b1;
            end
`else
            ST_T6: ;
`endif
            default: ;
        endcase
    end

    reg_sel_decoder u_reg_in_dec (
        .i_en     (w_rin_en),
        .i_sel    (w_ra),
        .o_onehot (reg_in)
    );

    reg_sel_decoder u_reg_out_dec (
        .i_en     (w_rout_en),
        .i_sel    (w_rout_sel),
        .o_onehot (reg_out)
    );

    assign alu_op      = w_alu_op;
    assign busy        = (r_state != ST_IDLE);
    assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Bench for alu_ctrl_sequencer: builds a cycle-by-cycle expected trace from the
// instruction timing table, drives it, and compares every output each cycle.
module tb_alu_ctrl_sequencer;

    localparam int WAIT_MAX = 15;
    localparam int C_BIN = 0, C_UN = 1, C_MD = 2, C_ILL = 3;
    localparam logic [31:0] IR_AND = 32'h28918000;

    logic        Clock = 1'b0;
    logic        Clear, run, mem_ready;
    logic [31:0] IR;
    logic        out_PC, MAR_in, IncPC, Z_in, out_Z_LO, out_Z_HI, PC_in, Read, MDR_in;
    logic        out_MDR, IR_in, Y_in, in_HI, in_LO, busy, instr_done, illegal_op, mem_timeout;
    logic [15:0] reg_in, reg_out;
    logic [3:0]  alu_op;

    typedef struct packed {
        logic out_PC, MAR_in, IncPC, Z_in, out_Z_LO, out_Z_HI, PC_in;
        logic Read, MDR_in, out_MDR, IR_in, Y_in, in_HI, in_LO;
        logic [15:0] reg_in;
        logic [15:0] reg_out;
        logic [3:0]  alu_op;
        logic busy, instr_done, illegal_op, mem_timeout;
    } obs_t;

    typedef struct {
        bit          clr;
        bit          rn;
        bit          mr;
        logic [31:0] ir;
        obs_t        exp;
        int          tag;
        bit          chk;
    } entry_t;

    entry_t plan[$];
    bit     at_idle   = 1'b1;
    bit     m_timeout = 1'b0;
    int     cur_idx   = 0;
    bit     cur_valid = 1'b0;
    bit     do_final  = 1'b0;
    bit     final_done = 1'b0;
    int     n_checks  = 0;
    int     n_err     = 0;
    int     tag_busy [8] = '{default: 0};
    int     tag_read [8] = '{default: 0};
    int     tag_pcin [8] = '{default: 0};
    int     tag_ill  [8] = '{default: 0};
    int     tag_y    [8] = '{default: 0};
    int     tag_hi   [8] = '{default: 0};
    int     tag_to   [8] = '{default: 0};
    int     tag_yreg [8] = '{default: 0};
    int     tag_rin  [8] = '{default: 0};

    alu_ctrl_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
        .Clock(Clock), .Clear(Clear), .run(run), .mem_ready(mem_ready), .IR(IR),
        .out_PC(out_PC), .MAR_in(MAR_in), .IncPC(IncPC), .Z_in(Z_in),
        .out_Z_LO(out_Z_LO), .out_Z_HI(out_Z_HI), .PC_in(PC_in), .Read(Read),
        .MDR_in(MDR_in), .out_MDR(out_MDR), .IR_in(IR_in), .Y_in(Y_in),
        .in_HI(in_HI), .in_LO(in_LO), .reg_in(reg_in), .reg_out(reg_out),
        .alu_op(alu_op), .busy(busy), .instr_done(instr_done),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    always #5 Clock = ~Clock;

    function automatic int op_class(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) return C_BIN;
        if (op == 5'd17 || op == 5'd18) return C_UN;
`ifdef ALU_SEQ_MULDIV_EN
        if (op == 5'd15 || op == 5'd16) return C_MD;
`endif
        return C_ILL;
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) return 4'(op - 5'd2);
        if (op >= 5'd15 && op <= 5'd18) return 4'(op - 5'd5);
        return 4'd0;
    endfunction

    function automatic obs_t base(input bit b);
        obs_t o;
        o = '0;
        o.busy = b;
        o.mem_timeout = m_timeout;
        return o;
    endfunction

    task automatic push_entry(input bit clr, input bit rn, input bit mr, input logic [31:0] ir,
                              input obs_t e, input int tag, input bit chk);
        entry_t x;
        x.clr = clr; x.rn = rn; x.mr = mr; x.ir = ir; x.exp = e; x.tag = tag; x.chk = chk;
        plan.push_back(x);
    endtask

    task automatic add_idle(input bit rn, input int tag);
        push_entry(1'b0, rn, 1'($urandom_range(0, 1)), $urandom, base(1'b0), tag, 1'b1);
    endtask

    task automatic add_clear(input int tag);
        push_entry(1'b1, 1'b1, 1'b1, $urandom, base(1'b0), tag, 1'b1);
        m_timeout = 1'b0;
        at_idle   = 1'b1;
    endtask

    // Expected trace of one instruction from its class, wait count and run at the end.
    task automatic add_instr(input logic [31:0] ir, input int waits, input bit run_end,
                             input int clear_step, input int tag);
        obs_t st[$];
        bit   mr[$];
        obs_t o;
        int   cls, n_fetch;
        bit   timed_out, rn;
        logic [3:0] ra, rb, rc;
        ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        cls = op_class(ir[31:27]);
        timed_out = (waits >= WAIT_MAX);
        if (at_idle) push_entry(1'b0, 1'b1, 1'($urandom_range(0, 1)), $urandom, base(1'b0), 0, 1'b1);
        o = base(1'b1); o.out_PC = 1; o.MAR_in = 1; o.IncPC = 1; o.Z_in = 1;
        st.push_back(o); mr.push_back(1'($urandom_range(0, 1)));
        for (int w = 0; w < WAIT_MAX && w <= waits; w++) begin
            o = base(1'b1); o.out_Z_LO = 1; o.PC_in = (w == 0); o.Read = 1; o.MDR_in = 1;
            st.push_back(o); mr.push_back(w == waits);
        end
        n_fetch = st.size();
        if (!timed_out) begin
            o = base(1'b1); o.out_MDR = 1; o.IR_in = 1;
            st.push_back(o); mr.push_back(1'($urandom_range(0, 1)));
            n_fetch = st.size();
            case (cls)
                C_BIN: begin
                    o = base(1'b1); o.reg_out = 16'd1 << rb; o.Y_in = 1; st.push_back(o);
                    o = base(1'b1); o.reg_out = 16'd1 << rc; o.alu_op = alu_of(ir[31:27]); o.Z_in = 1; st.push_back(o);
                    o = base(1'b1); o.out_Z_LO = 1; o.reg_in = 16'd1 << ra; o.instr_done = 1; st.push_back(o);
                end
                C_UN: begin
                    o = base(1'b1); o.reg_out = 16'd1 << rb; o.alu_op = alu_of(ir[31:27]); o.Z_in = 1; st.push_back(o);
                    o = base(1'b1); o.out_Z_LO = 1; o.reg_in = 16'd1 << ra; o.instr_done = 1; st.push_back(o);
                end
                C_MD: begin
                    o = base(1'b1); o.reg_out = 16'd1 << ra; o.Y_in = 1; st.push_back(o);
                    o = base(1'b1); o.reg_out = 16'd1 << rb; o.alu_op = alu_of(ir[31:27]); o.Z_in = 1; st.push_back(o);
                    o = base(1'b1); o.out_Z_LO = 1; o.in_LO = 1; st.push_back(o);
                    o = base(1'b1); o.out_Z_HI = 1; o.in_HI = 1; o.instr_done = 1; st.push_back(o);
                end
                default: begin
                    o = base(1'b1); o.illegal_op = 1; st.push_back(o);
                end
            endcase
            while (mr.size() < st.size()) mr.push_back(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < st.size(); i++) begin
            rn = 1'($urandom_range(0, 1));
            if (i == st.size() - 1 && !timed_out && cls != C_ILL) rn = run_end;
            push_entry(i == clear_step, rn, mr[i], (i < n_fetch) ? $urandom : ir, st[i], tag, 1'b1);
            if (i == clear_step) begin
                m_timeout = 1'b0;
                at_idle   = 1'b1;
                return;
            end
        end
        if (timed_out) begin
            m_timeout = 1'b1;
            at_idle   = 1'b1;
        end else if (cls == C_ILL) begin
            at_idle = 1'b0;
        end else begin
            at_idle = !run_end;
        end
    endtask

    task automatic pin(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    // Compare process: every planned cycle, then the literal pins once at the end.
    initial begin
        obs_t act;
        int   t;
        forever begin
            @(negedge Clock);
            if (cur_valid && plan[cur_idx].chk) begin
                act = {out_PC, MAR_in, IncPC, Z_in, out_Z_LO, out_Z_HI, PC_in, Read, MDR_in,
                       out_MDR, IR_in, Y_in, in_HI, in_LO, reg_in, reg_out, alu_op,
                       busy, instr_done, illegal_op, mem_timeout};
                t = plan[cur_idx].tag;
                n_checks++;
                if (act !== plan[cur_idx].exp) begin
                    n_err++;
                    $display("FAIL cycle %0d (tag %0d) outputs: got %h required %h",
                             cur_idx, t, act, plan[cur_idx].exp);
                end
                tag_busy[t] += int'(act.busy);
                tag_read[t] += int'(act.Read);
                tag_pcin[t] += int'(act.PC_in);
                tag_ill[t]  += int'(act.illegal_op);
                tag_y[t]    += int'(act.Y_in);
                tag_hi[t]   += int'(act.in_HI);
                tag_to[t]   += int'(act.mem_timeout);
                tag_rin[t]  |= int'(act.reg_in);
                if (act.Y_in) tag_yreg[t] = int'(act.reg_out);
            end
            if (do_final && !final_done) begin
                pin("and_latency", tag_busy[1], 6);
                pin("and_T3_reg_out", tag_yreg[1], 32'h0004);
                pin("and_T5_reg_in", tag_rin[1], 32'h0002);
                pin("wait_read_cycles", tag_read[2], 4);
                pin("wait_pc_in_cycles", tag_pcin[2], 1);
                pin("wait_latency", tag_busy[2], 9);
                pin("illegal_pulse", tag_ill[3], 1);
                pin("illegal_latency", tag_busy[3], 4);
                pin("illegal_reg_in", tag_rin[3], 0);
`ifdef ALU_SEQ_MULDIV_EN
                pin("mul_latency", tag_busy[4], 7);
                pin("mul_T3_reg_out", tag_yreg[4], 32'h0008);
                pin("mul_in_hi", tag_hi[4], 1);
`else
                pin("mul_illegal_pulse", tag_ill[4], 1);
                pin("mul_latency", tag_busy[4], 4);
                pin("mul_no_y_in", tag_y[4], 0);
`endif
                pin("wait14_latency", tag_busy[5], 20);
                pin("timeout_busy_cycles", tag_busy[6], 16);
                pin("timeout_flag_cycles", tag_to[6], 4);
                pin("clear_in_T4_busy", tag_busy[7], 5);
                final_done = 1'b1;
            end
        end
    end

    initial begin
        logic [4:0] op;
        int         waits, cstep;
        bit         rend;
        Clear = 1'b1; run = 1'b0; mem_ready = 1'b0; IR = '0;

        push_entry(1'b1, 1'b0, 1'b0, 32'd0, '0, 0, 1'b0);
        add_idle(1'b0, 0);
        add_idle(1'b0, 0);
        add_instr(IR_AND, 0, 1'b1, -1, 1);
        add_instr(IR_AND, 3, 1'b1, -1, 2);
        add_instr(32'hF8000000, 0, 1'b0, -1, 3);
        add_instr(32'h79A00000, 0, 1'b0, -1, 4);
        if (at_idle) add_idle(1'b0, 0);
        add_instr(IR_AND, 14, 1'b0, -1, 5);
        add_instr(IR_AND, 15, 1'b0, -1, 6);
        add_idle(1'b1, 6); add_idle(1'b1, 6); add_idle(1'b1, 6);
        add_clear(6);
        add_instr(IR_AND, 0, 1'b1, 4, 7);
        add_instr(IR_AND, 2, 1'b0, 2, 0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    op = 5'($urandom);
                2:       op = 5'(15 + $urandom_range(0, 1));
                3:       op = 5'(17 + $urandom_range(0, 1));
                default: op = 5'($urandom_range(3, 11));
            endcase
            waits = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) waits = 14;
            if ($urandom_range(0, 29) == 0) waits = 15;
            cstep = -1;
            if ($urandom_range(0, 9) == 0) cstep = $urandom_range(0, 7);
            rend = 1'($urandom_range(0, 1));
            if (at_idle && $urandom_range(0, 1) == 1) add_idle(1'b0, 0);
            add_instr({op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)},
                      waits, rend, cstep, 0);
            if (m_timeout) begin
                add_idle(1'b1, 0);
                add_clear(0);
            end
        end

        for (int i = 0; i < plan.size(); i++) begin
            @(posedge Clock); #1;
            Clear     = plan[i].clr;
            run       = plan[i].rn;
            mem_ready = plan[i].mr;
            IR        = plan[i].ir;
            cur_idx   = i;
            cur_valid = 1'b1;
        end
        @(posedge Clock); #1;
        cur_valid = 1'b0;
        do_final  = 1'b1;
        @(negedge Clock); #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
